// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the synchronous nibble FIFO and its drain stages:
// UART transmitter state encodings and the parity-mode selection.
package sync_fifo_pkg;

  // 3-bit encodings of the serialiser FSM states.
  localparam logic [2:0] ST_IDLE_ENC   = 3'd0;
  localparam logic [2:0] ST_FETCH_ENC  = 3'd1;
  localparam logic [2:0] ST_LOAD_ENC   = 3'd2;
  localparam logic [2:0] ST_START_ENC  = 3'd3;
  localparam logic [2:0] ST_DATA_ENC   = 3'd4;
  localparam logic [2:0] ST_PARITY_ENC = 3'd5;
  localparam logic [2:0] ST_STOP_ENC   = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE_ENC,
    S_FETCH  = ST_FETCH_ENC,
    S_LOAD   = ST_LOAD_ENC,
    S_START  = ST_START_ENC,
    S_DATA   = ST_DATA_ENC,
    S_PARITY = ST_PARITY_ENC,
    S_STOP   = ST_STOP_ENC
  } tx_state_e;

  // Parity mode: 1'b0 gives even parity (bit = XOR of data), 1'b1 would give odd.
  localparam logic PARITY_ODD = 1'b0;

  // Parity bit to transmit, given the XOR-reduction of the data word.
  function automatic logic parity_bit(input logic data_xor);
    return data_xor ^ PARITY_ODD;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Baud-rate divider: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// final cycle of each serial bit. A clear input restarts the bit period.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tick_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, otherwise advance and wrap on the bit boundary.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign tick_o = en_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/fifo_nibble_uart_tx.sv
// Drain stage for the nibble FIFO: pops one word at a time and sends it as a
// UART frame (start, data LSB-first, optional even parity, stop bits) on tx.
// tx, fifo_rd_en and frame_done are computed from the next state and
// registered, so they line up with the state register and have no
// combinational path from the inputs.
module fifo_nibble_uart_tx
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = 4,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_WIDTH + 1);

  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);
  // frame_done is registered, so it is armed one cycle before the last stop cycle.
  localparam logic [CNT_W-1:0] DONE_CNT  = CNT_W'(CLKS_PER_BIT - 2);

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  parity_q, parity_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  tx_q, tx_d;
  logic                  rd_en_q, rd_en_d;
  logic                  done_q, done_d;

  logic                  baud_clr;
  logic                  baud_en;
  logic                  baud_tick;
  logic [CNT_W-1:0]      baud_cnt;

  assign baud_clr = (state_q == S_LOAD);
  assign baud_en  = (state_q == S_START) || (state_q == S_DATA) ||
                    (state_q == S_PARITY) || (state_q == S_STOP);

  baud_tick_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_baud (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (baud_clr),
    .en_i   (baud_en),
    .cnt_o  (baud_cnt),
    .tick_o (baud_tick)
  );

  // Next-state, datapath and next-output logic of the frame sequencer.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    bit_cnt_d = bit_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (ena && !fifo_empty) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        shift_d   = fifo_rd_data;
        parity_d  = parity_bit(^fifo_rd_data);
        bit_cnt_d = '0;
        state_d   = S_START;
      end
      S_START: begin
        if (baud_tick) begin
          state_d = S_DATA;
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            state_d   = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_PARITY: begin
        if (baud_tick) begin
          bit_cnt_d = '0;
          state_d   = S_STOP;
        end else begin
          state_d = S_PARITY;
        end
      end
      S_STOP: begin
        if (baud_tick) begin
          if (bit_cnt_q == LAST_STOP) begin
            bit_cnt_d = '0;
            if (ena && !fifo_empty) begin
              state_d = S_FETCH;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end else begin
          state_d = S_STOP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Line level follows the state being entered so the register matches state_q.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = parity_d;
      default:  tx_d = 1'b1;
    endcase

    rd_en_d = (state_d == S_FETCH);
    done_d  = (state_q == S_STOP) && (bit_cnt_q == LAST_STOP) &&
              (baud_cnt == DONE_CNT);
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      rd_en_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      rd_en_q   <= rd_en_d;
      done_q    <= done_d;
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign tx         = tx_q;
  assign frame_done = done_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_fifo_nibble_uart_tx.sv
// Directed bench for fifo_nibble_uart_tx with CLKS_PER_BIT=4. Instance A has
// no parity (F=24), instance B has even parity (F=28). Each instance reads
// from a small FIFO model driven by the bench.
module tb_fifo_nibble_uart_tx;

  localparam int CPB = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // FIFO models
  logic [3:0] mem_a [16];
  logic [3:0] mem_b [16];
  logic [3:0] wr_a = 4'd0, rd_a = 4'd0, wr_b = 4'd0, rd_b = 4'd0;
  logic [3:0] rd_data_a = 4'd0, rd_data_b = 4'd0;
  logic       empty_a, empty_b;
  assign empty_a = (wr_a == rd_a);
  assign empty_b = (wr_b == rd_b);

  logic ena_a = 1'b0, ena_b = 1'b0;
  logic rd_en_a, tx_a, busy_a, done_a;
  logic rd_en_b, tx_b, busy_b, done_b;

  fifo_nibble_uart_tx #(.DATA_WIDTH(4), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .ena(ena_a), .fifo_empty(empty_a), .fifo_rd_data(rd_data_a),
    .fifo_rd_en(rd_en_a), .tx(tx_a), .busy(busy_a), .frame_done(done_a)
  );

  fifo_nibble_uart_tx #(.DATA_WIDTH(4), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .ena(ena_b), .fifo_empty(empty_b), .fifo_rd_data(rd_data_b),
    .fifo_rd_en(rd_en_b), .tx(tx_b), .busy(busy_b), .frame_done(done_b)
  );

  // FIFO read side: data valid the cycle after the pop request.
  always @(posedge clk) begin
    if (rd_en_a) begin
      rd_data_a <= mem_a[rd_a];
      rd_a      <= rd_a + 4'd1;
    end
    if (rd_en_b) begin
      rd_data_b <= mem_b[rd_b];
      rd_b      <= rd_b + 4'd1;
    end
  end

  // Select which instance the frame checker observes.
  logic sel = 1'b0;
  logic tx_s, rd_en_s, busy_s, done_s;
  always_comb begin
    tx_s    = sel ? tx_b    : tx_a;
    rd_en_s = sel ? rd_en_b : rd_en_a;
    busy_s  = sel ? busy_b  : busy_a;
    done_s  = sel ? done_b  : done_a;
  end

  typedef struct {
    bit         s;      // 0 = instance A, 1 = instance B (parity)
    logic [3:0] word;
    logic [7:0] bits;   // bits[i] = level of serial bit i (start first)
    int         nbits;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %b required %b", name, act, exp);
    end
  endtask

  task automatic push(input bit s, input logic [3:0] w);
    if (s) begin
      mem_b[wr_b] = w;
      wr_b = wr_b + 4'd1;
    end else begin
      mem_a[wr_a] = w;
      wr_a = wr_a + 4'd1;
    end
  endtask

  task automatic wait_pop(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rd_en_s) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s pop: no fifo_rd_en within 50 cycles", name);
    end
  endtask

  // Checks one frame from the pop cycle onward, cycle by cycle.
  task automatic check_frame(input string name, input logic [7:0] bits, input int nbits,
                             input bit immediate, input int drop_at);
    bit ok;
    logic [7:0] b;
    int flen;
    b    = bits;
    flen = nbits * CPB;
    if (immediate) begin
      @(negedge clk);
      chk($sformatf("%s b2b rd_en", name), rd_en_s, 1'b1);
      ok = rd_en_s;
    end else begin
      wait_pop(name, ok);
    end
    if (ok) begin
      chk($sformatf("%s fetch tx", name), tx_s, 1'b1);
      @(negedge clk);
      chk($sformatf("%s load tx", name), tx_s, 1'b1);
      chk($sformatf("%s load rd_en", name), rd_en_s, 1'b0);
      chk($sformatf("%s load busy", name), busy_s, 1'b1);
      for (int c = 0; c < flen; c++) begin
        @(negedge clk);
        if (c == drop_at) ena_a = 1'b0;
        chk($sformatf("%s tx c%0d", name, c), tx_s, b[c / CPB]);
        chk($sformatf("%s frame_done c%0d", name, c), done_s, (c == flen - 1));
        if (c < flen - 1) chk($sformatf("%s busy c%0d", name, c), busy_s, 1'b1);
      end
    end
  endtask

  initial begin
    // start, data LSB-first, [parity], stop
    vecs[0] = '{1'b0, 4'hA, 8'b0011_0100, 6};
    vecs[1] = '{1'b0, 4'h5, 8'b0010_1010, 6};
    vecs[2] = '{1'b0, 4'hF, 8'b0011_1110, 6};
    vecs[3] = '{1'b0, 4'h3, 8'b0010_0110, 6};
    vecs[4] = '{1'b1, 4'h7, 8'b0110_1110, 7};
    vecs[5] = '{1'b1, 4'h0, 8'b0100_0000, 7};
    vecs[6] = '{1'b1, 4'h5, 8'b0100_1010, 7};
    vecs[7] = '{1'b1, 4'h8, 8'b0111_0000, 7};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset tx_a", tx_a, 1'b1);
    chk("reset busy_a", busy_a, 1'b0);
    chk("reset rd_en_a", rd_en_a, 1'b0);
    chk("reset done_a", done_a, 1'b0);
    chk("reset tx_b", tx_b, 1'b1);
    chk("reset busy_b", busy_b, 1'b0);
    rst_n = 1'b1;

    // Table-driven single frames
    ena_a = 1'b1;
    ena_b = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sel = vecs[i].s;
      push(vecs[i].s, vecs[i].word);
      check_frame($sformatf("vec%0d", i), vecs[i].bits, vecs[i].nbits, 1'b0, -1);
      @(negedge clk);
      chk($sformatf("vec%0d idle busy", i), busy_s, 1'b0);
      chk($sformatf("vec%0d idle tx", i), tx_s, 1'b1);
    end

    // Back-to-back 3, C
    sel = 1'b0;
    push(1'b0, 4'h3);
    push(1'b0, 4'hC);
    check_frame("b2b0", 8'b0010_0110, 6, 1'b0, -1);
    check_frame("b2b1", 8'b0011_1000, 6, 1'b1, -1);
    @(negedge clk);
    chk("b2b idle busy", busy_a, 1'b0);
    chk("b2b fifo empty", empty_a, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("b2b no extra pop", rd_en_a, 1'b0);
    end

    // Empty FIFO with ena=1
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("empty rd_en", rd_en_a, 1'b0);
      chk("empty tx", tx_a, 1'b1);
      chk("empty busy", busy_a, 1'b0);
    end

    // ena drop during DATA bit 1 (cycles 8..11 of the frame)
    push(1'b0, 4'h5);
    push(1'b0, 4'hF);
    check_frame("enadrop", 8'b0010_1010, 6, 1'b0, 8);
    @(negedge clk);
    chk("enadrop idle busy", busy_a, 1'b0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("enadrop no pop", rd_en_a, 1'b0);
      chk("enadrop busy", busy_a, 1'b0);
    end
    chk("enadrop word kept", empty_a, 1'b0);
    ena_a = 1'b1;
    check_frame("enadrop resume", 8'b0011_1110, 6, 1'b0, -1);
    @(negedge clk);
    chk("enadrop resume idle", busy_a, 1'b0);

    // Reset mid-frame during DATA
    begin
      bit ok;
      push(1'b0, 4'hA);
      wait_pop("rst", ok);
      @(negedge clk);
      for (int c = 0; c < 10; c++) @(negedge clk);
      chk("rst pre busy", busy_a, 1'b1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst tx", tx_a, 1'b1);
      chk("rst busy", busy_a, 1'b0);
      chk("rst rd_en", rd_en_a, 1'b0);
      chk("rst done", done_a, 1'b0);
      rst_n = 1'b1;
      chk("rst word lost", empty_a, 1'b1);
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        chk("rst idle tx", tx_a, 1'b1);
        chk("rst idle busy", busy_a, 1'b0);
      end
      push(1'b0, 4'hC);
      check_frame("rst fresh", 8'b0011_1000, 6, 1'b0, -1);
      @(negedge clk);
      chk("rst fresh idle", busy_a, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
